// File: rtl/uart_pkg.sv
// uart_pkg: line settings and FSM states shared by uart_tx, uart_rx and uart_tx_queue
//   CLK_FREQ, BAUD, FRAME_BITS : default line settings
//   frame_cycles()             : clock cycles per UART frame
//   state_t                    : pacing FSM states
package uart_pkg;

    localparam int CLK_FREQ   = 100_000_000;
    localparam int BAUD       = 9600;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic int frame_cycles(input int clk_freq, input int baud, input int frame_bits);
        return (clk_freq / baud) * frame_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular byte FIFO with registered occupancy flags
//   clk, reset (async active-low)
//   push/wdata : write request; accepted when not full or when a pop happens in the same cycle
//   pop/rdata  : read request; rdata is the current head
//   full, empty, count : occupancy after the last edge
//   dropped    : this cycle's push is being rejected
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      count_nx;
    logic             do_push, do_pop;

    // full is judged before this cycle's pop, so a pop makes room for a same-cycle push
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign dropped  = push && !do_push;
    assign count_nx = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign rdata    = mem[rp];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count_nx;
            full  <= count_nx == (AW+1)'(DEPTH);
            empty <= count_nx == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffers game-logic bytes and paces them into uart_tx, one per frame time
//   clk, reset (async active-low)
//   wr_data/wr_en          : byte push from game logic
//   full, empty, count     : FIFO occupancy
//   overflow               : sticky, set when a push is dropped
//   tx_data/tx_start       : to uart_tx; one-cycle start pulse per byte, data held for the frame
//   tx_busy                : frame in progress
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int CLK_FREQ     = uart_pkg::CLK_FREQ,
    parameter int BAUD         = uart_pkg::BAUD,
    parameter int FRAME_BITS   = uart_pkg::FRAME_BITS,
    parameter int FRAME_CYCLES = frame_cycles(CLK_FREQ, BAUD, FRAME_BITS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    output logic                     tx_busy
);
    localparam int CW = $clog2(FRAME_CYCLES);

    if (FRAME_CYCLES < 2) begin : g_bad_frame
        $error("uart_tx_queue: FRAME_CYCLES must be >= 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_queue: DEPTH must be a power of 2 and >= 2");
    end

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [7:0]    head;
    logic          pop, dropped;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_en),
        .pop     (pop),
        .wdata   (wr_data),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .dropped (dropped)
    );

    assign pop     = state == IDLE && !empty;
    assign tx_busy = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = empty ? IDLE : START;
            START:   state_nx = WAIT;
            WAIT:    state_nx = cnt == '0 ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // START plus FRAME_CYCLES-1 WAIT cycles spans one frame; tx_start trails the START cycle by one edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= state == START ? CW'(FRAME_CYCLES - 2) : (state == WAIT && cnt != '0) ? cnt - 1'b1 : cnt;
            tx_data  <= pop ? head : tx_data;
            tx_start <= state == START;
            overflow <= overflow | dropped;
        end
    end

endmodule
